// File: rtl/imm_gen_stage.sv
// Registered RISC-V immediate generator for the decode stage (RV32/RV64).
// One output register behind a valid/ready handshake, with flush and an illegal-opcode counter.
module imm_gen_stage #(
  parameter int XLEN       = 32,
  parameter bit ENABLE_CSR = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ZIMM  = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_stage: XLEN must be 32 or 64");
    end
  endgenerate

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_shamt;
  logic [XLEN-1:0] imm_zimm;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];

  assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0};
  assign imm_zimm = {{(XLEN-5){1'b0}}, in_instr[19:15]};

  // RV64 shifts take a 6-bit shamt; on RV32 bit 25 belongs to funct7 and is ignored.
  generate
    if (XLEN == 64) begin : g_shamt64
      assign imm_shamt = {{(XLEN-6){1'b0}}, in_instr[25:20]};
    end else begin : g_shamt32
      assign imm_shamt = {{(XLEN-5){1'b0}}, in_instr[24:20]};
    end
  endgenerate

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;

  always_comb begin
    dec_imm     = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    case (opcode)
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_imm = imm_shamt;
          dec_fmt = FMT_SHAMT;
        end else begin
          dec_imm = imm_i;
          dec_fmt = FMT_I;
        end
      end
      OP_LOAD, OP_JALR: begin
        dec_imm = imm_i;
        dec_fmt = FMT_I;
      end
      OP_STORE: begin
        dec_imm = imm_s;
        dec_fmt = FMT_S;
      end
      OP_BRANCH: begin
        dec_imm = imm_b;
        dec_fmt = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        dec_imm = imm_u;
        dec_fmt = FMT_U;
      end
      OP_JAL: begin
        dec_imm = imm_j;
        dec_fmt = FMT_J;
      end
      OP_SYSTEM: begin
        if (ENABLE_CSR && funct3[2]) begin
          dec_imm = imm_zimm;
          dec_fmt = FMT_ZIMM;
        end else begin
          dec_imm = imm_i;
          dec_fmt = FMT_I;
        end
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  logic accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Flush wins over accept; a pop with no push empties the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_instr     <= '0;
      out_imm       <= '0;
      out_fmt       <= FMT_NONE;
      out_illegal   <= 1'b0;
      illegal_count <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_instr   <= in_instr;
      out_imm     <= dec_imm;
      out_fmt     <= dec_fmt;
      out_illegal <= dec_illegal;
      if (dec_illegal && illegal_count != CNT_MAX) begin
        illegal_count <= illegal_count + 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: an RV32 instance (CSR zimm on, 2-bit counter) and an RV64 instance
// (CSR zimm off) share stimulus and are compared against a behavioural decode model.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [31:0] in_instr;

  logic        r32, v32, l32;
  logic [31:0] i32, m32;
  logic [2:0]  f32;
  logic [1:0]  c32;

  logic        r64, v64, l64;
  logic [31:0] i64;
  logic [63:0] m64;
  logic [2:0]  f64;
  logic [15:0] c64;

  int total = 0;
  int bad   = 0;

  bit          m_valid;
  logic [31:0] m_instr;
  logic [63:0] m_imm32, m_imm64;
  logic [2:0]  m_fmt32, m_fmt64;
  bit          m_ill;
  int          m_cnt32, m_cnt64;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .ENABLE_CSR(1'b1), .CNT_W(2)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r32), .in_instr(in_instr),
    .flush(flush), .out_valid(v32), .out_ready(out_ready), .out_instr(i32), .out_imm(m32),
    .out_fmt(f32), .out_illegal(l32), .illegal_count(c32)
  );

  imm_gen_stage #(.XLEN(64), .ENABLE_CSR(1'b0), .CNT_W(16)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r64), .in_instr(in_instr),
    .flush(flush), .out_valid(v64), .out_ready(out_ready), .out_instr(i64), .out_imm(m64),
    .out_fmt(f64), .out_illegal(l64), .illegal_count(c64)
  );

  // Immediate value as a signed integer, then truncated to the datapath width.
  function automatic logic [63:0] ref_imm(logic [31:0] ins, int xlen, bit csr);
    longint v;
    logic [2:0] f3;
    f3 = ins[14:12];
    case (ins[6:0])
      7'b0010011: if (f3 == 3'd1 || f3 == 3'd5) v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
                  else v = $signed(ins[31:20]);
      7'b0000011, 7'b1100111: v = $signed(ins[31:20]);
      7'b0100011: v = $signed({ins[31:25], ins[11:7]});
      7'b1100011: v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      7'b0110111, 7'b0010111: v = $signed({ins[31:12], 12'b0});
      7'b1101111: v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      7'b1110011: if (csr && ins[14]) v = longint'(ins[19:15]);
                  else v = $signed(ins[31:20]);
      default: v = 0;
    endcase
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  function automatic logic [2:0] ref_fmt(logic [31:0] ins, bit csr);
    logic [2:0] f3;
    f3 = ins[14:12];
    case (ins[6:0])
      7'b0010011: return (f3 == 3'd1 || f3 == 3'd5) ? 3'd6 : 3'd1;
      7'b0000011, 7'b1100111: return 3'd1;
      7'b0100011: return 3'd2;
      7'b1100011: return 3'd3;
      7'b0110111, 7'b0010111: return 3'd4;
      7'b1101111: return 3'd5;
      7'b1110011: return (csr && ins[14]) ? 3'd7 : 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [11] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
                            7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b0110011, 7'b0000000};
    logic [31:0] r;
    r = $urandom();
    r[6:0] = ops[$urandom_range(0, 10)];
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_instr = '0; m_imm32 = '0; m_imm64 = '0;
    m_fmt32 = '0; m_fmt64 = '0; m_ill = 0; m_cnt32 = 0; m_cnt64 = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven, then step to just after the edge.
  task automatic tick();
    bit rdy;
    rdy = !m_valid || out_ready;
    if (!rst_n) model_reset();
    else if (flush) m_valid = 0;
    else if (in_valid && rdy) begin
      m_valid = 1;
      m_instr = in_instr;
      m_imm32 = ref_imm(in_instr, 32, 1);
      m_imm64 = ref_imm(in_instr, 64, 0);
      m_fmt32 = ref_fmt(in_instr, 1);
      m_fmt64 = ref_fmt(in_instr, 0);
      m_ill   = (m_fmt32 == 3'd0);
      if (m_ill) begin
        if (m_cnt32 < 3) m_cnt32++;
        if (m_cnt64 < 65535) m_cnt64++;
      end
    end else if (out_ready) m_valid = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; flush = 0; out_ready = 0; in_instr = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    total++;
    if ({r32, r64} !== 2'b11) begin
      bad++; $display("[TB] FAIL reset_in_ready got=%b want=11", {r32, r64});
    end
    total++;
    if ({v32, i32, m32, f32, l32, c32, v64, i64, m64, f64, l64, c64} !== '0) begin
      bad++; $display("[TB] FAIL reset_outputs got32=%h/%h/%h/%h/%h/%h got64=%h/%h/%h/%h/%h/%h want all zero",
                      v32, i32, m32, f32, l32, c32, v64, i64, m64, f64, l64, c64);
    end
    rst_n = 1;
  endtask

  task automatic test_xlen32();
    logic [31:0] words [4] = '{32'hFFF00093, 32'hFE209EE3, 32'h00512423, 32'h4030D093};
    logic [31:0] want  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000008, 32'h00000003};
    logic [2:0]  wfmt  [4] = '{3'd1, 3'd3, 3'd2, 3'd6};
    out_ready = 1; flush = 0; in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      in_instr = words[k];
      tick();
      total++;
      if ({v32, m32, f32, l32} !== {1'b1, want[k], wfmt[k], 1'b0}) begin
        bad++; $display("[TB] FAIL x32_word%0d got v=%b imm=%h fmt=%0d ill=%b want v=1 imm=%h fmt=%0d ill=0",
                        k, v32, m32, f32, l32, want[k], wfmt[k]);
      end
      total++;
      if ({v64, i64, m64, f64, l64, c64} !== {m_valid, m_instr, m_imm64, m_fmt64, m_ill, m_cnt64[15:0]}) begin
        bad++; $display("[TB] FAIL x32_word%0d_rv64 got imm=%h fmt=%0d want imm=%h fmt=%0d",
                        k, m64, f64, m_imm64, m_fmt64);
      end
    end
    in_valid = 0;
    tick();
    total++;
    if ({v32, v64} !== 2'b00) begin
      bad++; $display("[TB] FAIL x32_drain got=%b want=00", {v32, v64});
    end
  endtask

  task automatic test_xlen64();
    logic [31:0] words [3] = '{32'h123450B7, 32'h800000B7, 32'h0200D093};
    logic [63:0] want  [3] = '{64'h0000000012345000, 64'hFFFFFFFF80000000, 64'h20};
    logic [2:0]  wfmt  [3] = '{3'd4, 3'd4, 3'd6};
    out_ready = 1; flush = 0; in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      in_instr = words[k];
      tick();
      total++;
      if ({v64, m64, f64, i64} !== {1'b1, want[k], wfmt[k], words[k]}) begin
        bad++; $display("[TB] FAIL x64_word%0d got imm=%h fmt=%0d instr=%h want imm=%h fmt=%0d instr=%h",
                        k, m64, f64, i64, want[k], wfmt[k], words[k]);
      end
      total++;
      if ({v32, i32, m32, f32, l32} !== {m_valid, m_instr, m_imm32[31:0], m_fmt32, m_ill}) begin
        bad++; $display("[TB] FAIL x64_word%0d_rv32 got imm=%h fmt=%0d want imm=%h fmt=%0d",
                        k, m32, f32, m_imm32[31:0], m_fmt32);
      end
    end
  endtask

  task automatic test_backpressure();
    in_valid = 1; out_ready = 1; flush = 0; in_instr = 32'hFFF00093;
    tick();
    out_ready = 0; in_instr = 32'h00512423;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if ({r32, r64} !== 2'b00) begin
        bad++; $display("[TB] FAIL stall_ready cycle%0d got=%b want=00", k, {r32, r64});
      end
      tick();
      total++;
      if ({v32, i32, m32, f32, v64, m64} !== {1'b1, 32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b1, 64'hFFFFFFFFFFFFFFFF}) begin
        bad++; $display("[TB] FAIL stall_hold cycle%0d got v=%b instr=%h imm=%h fmt=%0d imm64=%h want held addi -1",
                        k, v32, i32, m32, f32, m64);
      end
    end
    out_ready = 1;
    #1;
    total++;
    if ({r32, r64} !== 2'b11) begin
      bad++; $display("[TB] FAIL release_ready got=%b want=11", {r32, r64});
    end
    tick();
    total++;
    if ({v32, m32, f32, v64, m64} !== {1'b1, 32'h8, 3'd2, 1'b1, 64'h8}) begin
      bad++; $display("[TB] FAIL release_push got v=%b imm=%h fmt=%0d imm64=%h want v=1 imm=8 fmt=2",
                      v32, m32, f32, m64);
    end
  endtask

  task automatic test_illegal_flush();
    in_valid = 1; out_ready = 1; flush = 0; in_instr = 32'h0;
    tick();
    total++;
    if ({v32, l32, f32, c32, l64, c64} !== {1'b1, 1'b1, 3'd0, 2'd1, 1'b1, 16'd1}) begin
      bad++; $display("[TB] FAIL illegal_one got v=%b ill=%b fmt=%0d cnt=%0d cnt64=%0d want 1/1/0/1/1",
                      v32, l32, f32, c32, c64);
    end
    flush = 1;
    tick();
    total++;
    if ({v32, v64, c32, c64} !== {1'b0, 1'b0, 2'd1, 16'd1}) begin
      bad++; $display("[TB] FAIL flush_kill got v=%b%b cnt=%0d cnt64=%0d want v=00 cnt=1", v32, v64, c32, c64);
    end
    flush = 0;
    for (int k = 0; k < 5; k++) tick();
    total++;
    if ({c32, c64} !== {2'd3, 16'd6}) begin
      bad++; $display("[TB] FAIL count_saturate got cnt=%0d cnt64=%0d want cnt=3 cnt64=6", c32, c64);
    end
  endtask

  task automatic test_csr_and_async_reset();
    in_valid = 1; out_ready = 1; flush = 0; in_instr = 32'h3400D073;
    tick();
    total++;
    if ({m32, f32, m64, f64} !== {32'h1, 3'd7, 64'h340, 3'd1}) begin
      bad++; $display("[TB] FAIL csr_zimm got imm=%h fmt=%0d imm64=%h fmt64=%0d want 1/7 and 340/1",
                      m32, f32, m64, f64);
    end
    out_ready = 0; in_instr = 32'hFFF00093;
    tick(); tick();
    #2;
    rst_n = 0;
    #1;
    model_reset();
    total++;
    if ({v32, c32, v64, c64, r32, r64} !== {1'b0, 2'd0, 1'b0, 16'd0, 1'b1, 1'b1}) begin
      bad++; $display("[TB] FAIL async_reset got v=%b cnt=%0d v64=%b cnt64=%0d rdy=%b%b want 0/0/0/0/11",
                      v32, c32, v64, c64, r32, r64);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_instr  = rand_instr();
      #1;
      total++;
      if ({r32, r64} !== {2{!m_valid || out_ready}}) begin
        bad++; $display("[TB] FAIL rand_ready n=%0d got=%b want=%b", n, {r32, r64}, {2{!m_valid || out_ready}});
      end
      tick();
      total++;
      if ({v32, i32, m32, f32, l32, c32} !== {m_valid, m_instr, m_imm32[31:0], m_fmt32, m_ill, m_cnt32[1:0]}) begin
        bad++; $display("[TB] FAIL rand_rv32 n=%0d got v=%b instr=%h imm=%h fmt=%0d ill=%b cnt=%0d want v=%b instr=%h imm=%h fmt=%0d ill=%b cnt=%0d",
                        n, v32, i32, m32, f32, l32, c32, m_valid, m_instr, m_imm32[31:0], m_fmt32, m_ill, m_cnt32);
      end
      total++;
      if ({v64, i64, m64, f64, l64, c64} !== {m_valid, m_instr, m_imm64, m_fmt64, m_ill, m_cnt64[15:0]}) begin
        bad++; $display("[TB] FAIL rand_rv64 n=%0d got v=%b instr=%h imm=%h fmt=%0d ill=%b cnt=%0d want v=%b instr=%h imm=%h fmt=%0d ill=%b cnt=%0d",
                        n, v64, i64, m64, f64, l64, c64, m_valid, m_instr, m_imm64, m_fmt64, m_ill, m_cnt64);
      end
    end
  endtask

  initial begin
    test_reset();
    test_xlen32();
    test_xlen64();
    test_backpressure();
    test_illegal_flush();
    test_csr_and_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Registered, parametrised RISC-V immediate generator for the decode stage. It covers every base-ISA immediate format (I, S, B, U, J), shift-amount immediates and CSR zimm, and targets either RV32 or RV64. The block has one pipeline register with a valid/ready handshake and a flush input, and sits between instruction fetch/decode and the execute stage. A saturating counter records how many accepted instructions had an unsupported opcode.

Parameters:
XLEN, 32, datapath width. Legal values are 32 and 64; any other value is an elaboration error.
ENABLE_CSR, 1, enables zimm extraction for CSR-immediate instructions.
CNT_W, 16, width of the illegal-opcode counter.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  instruction word present.
in_ready  output  1  stage can accept an instruction this cycle.
in_instr  input  32  instruction word.
flush  input  1  synchronous kill of the stage contents.
out_valid  output  1  output register holds a result.
out_ready  input  1  consumer accepts the result.
out_instr  output  32  instruction word, passed through aligned with the result.
out_imm  output  XLEN  extended immediate.
out_fmt  output  3  format code: 0=none, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SHAMT, 7=ZIMM.
out_illegal  output  1  opcode not supported.
illegal_count  output  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Reset (asynchronous, on rst_n low): out_valid=0, out_instr=0, out_imm=0, out_fmt=0, out_illegal=0, illegal_count=0. in_ready=1 while reset is held.
- Handshake: in_ready = !out_valid || out_ready, computed combinationally.
- Accept: an instruction is accepted when in_valid && in_ready. The result is registered on that rising edge (latency 1).
- Stall: while out_valid && !out_ready, all output registers hold stable.
- Flush: has priority over accept. On a flush cycle, out_valid goes to 0 at the next edge, nothing is captured, and illegal_count does not increment.
- Decode is by opcode, in_instr[6:0]. "sext" means sign-extend from the top bit of the field to XLEN.
  - 0010011 (OP-IMM):
    - funct3=001 or 101: imm = zero-extended shamt. Shamt is in_instr[24:20] when XLEN=32, in_instr[25:20] when XLEN=64. fmt=6.
    - otherwise: sext(in_instr[31:20]), fmt=1.
  - 0000011 (LOAD) and 1100111 (JALR): sext(in_instr[31:20]), fmt=1.
  - 0100011 (STORE): sext({in_instr[31:25], in_instr[11:7]}), fmt=2.
  - 1100011 (BRANCH): sext({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}), fmt=3.
  - 0110111 (LUI) and 0010111 (AUIPC): sext({in_instr[31:12], 12'b0}), fmt=4. With XLEN=64, bit 31 is replicated into [63:32].
  - 1101111 (JAL): sext({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}), fmt=5.
  - 1110011 (SYSTEM):
    - ENABLE_CSR=1 and funct3[2]=1: imm = zero-extended in_instr[19:15], fmt=7.
    - otherwise: sext(in_instr[31:20]), fmt=1.
  - Any other opcode: imm=0, fmt=0, out_illegal=1.
- illegal_count: increments by 1 on each accepted illegal instruction that is not flushed. It saturates at 2^CNT_W-1 and does not wrap.
- Reset asserted mid-stall: the held result is discarded immediately.
- Combined pop and push: with out_valid=1, out_ready=1 and in_valid=1 in the same cycle, the new result replaces the old one with no bubble.

Test Plan:
- XLEN=32. Accept 0xFFF00093 (addi -1) -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1, out_illegal=0.
- Accept 0xFE209EE3 (bne -4) -> out_imm=0xFFFFFFFC, fmt=3. Then 0x00512423 (sw offset 8) -> out_imm=0x00000008, fmt=2. Then 0x4030D093 (srai 3) -> out_imm=0x00000003, fmt=6 (not 0x403).
- XLEN=64. 0x123450B7 -> out_imm=0x0000000012345000, fmt=4. Then 0x800000B7 -> out_imm=0xFFFFFFFF80000000. Then 0x0200D093 (srli 32) -> out_imm=0x20.
- Backpressure: out_ready=0 after accepting 0xFFF00093 -> in_ready=0 and outputs stable for 5 cycles while in_valid=1 with 0x00512423. Raise out_ready -> the stored word is accepted that edge and out_imm=0x8 on the next cycle, with no bubble.
- Illegal and flush: 0x00000000 accepted -> out_illegal=1, fmt=0, illegal_count=1. Then 0x00000000 presented with flush=1 -> out_valid=0 and count stays 1. Drive CNT_W=2 with 5 illegal words -> count saturates at 3.
- ENABLE_CSR=1: 0x3400D073 (csrrwi zimm=1) -> out_imm=0x1, fmt=7. Assert rst_n=0 during a stall -> out_valid=0 and illegal_count=0 immediately, without waiting for a clock edge.
